serial_and16: RTL and testbench

Bit-serial counterpart of the 16-bit parallel AND stage in the chapter-1 gate library. It accepts two 16-bit operands over a valid/ready handshake and evaluates the bitwise AND with a single 1-bit `and` primitive, one bit per clock, LSB first. It presents the 16-bit result over a second valid/ready handshake. It trades 16 gates for a shift datapath and a small control FSM, and is a drop-in where parallel AND area is not available.

---
 rtl/serial_and16_if.sv | 33 +++
 rtl/serial_and16.sv | 117 +++++++++++
 tb/tb_serial_and16.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_and16_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_and16_if
//  Description : Operand/result handshake bundle for serial_and16.
//                master = producer/consumer side, slave = serial_and16.
//                in_valid/in_ready/in0/in1 : operand handshake
//                out_valid/out_ready/out   : result handshake
//                busy                      : operation in flight
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_and16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, in0, in1, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, in0, in1, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_and16.sv
`default_nettype none
// ============================================================================
//  Module      : serial_and16
//  Description : Bit-serial bitwise AND of two WIDTH-bit operands. One 1-bit
//                AND gate processes one bit per clock, LSB first; the result
//                is presented over a valid/ready handshake.
//  Ports       : clk   - sole clock, rising edge
//                reset - asynchronous, active-high
//                bus   - serial_and16_if.slave (operand/result handshakes,
//                        busy status)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_and16 #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    serial_and16_if.slave    bus
);

    localparam int            c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_r;
    logic [WIDTH-1:0]     r_out;
    logic [c_cnt_w-1:0]   r_cnt;
    wire logic            w_bit;
    logic [WIDTH-1:0]     w_r_next;
    logic                 w_last;

    // The single AND gate of the datapath.
    and u_and (w_bit, r_a[0], r_b[0]);

    // Result bits enter at the MSB and migrate down, so after WIDTH shifts
    // the LSB of the operands lands in bit 0.
    assign w_r_next = {w_bit, r_r[WIDTH-1:1]};
    assign w_last   = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, accumulator, counter, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.in0;
                        r_b   <= bus.in1;
                        r_r   <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_r <= w_r_next;
                    r_a <= r_a >> 1;
                    r_b <= r_b >> 1;
                    // Counter parks at the last value; only acceptance clears it.
                    if (w_last) begin
                        r_out <= w_r_next;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs come from registers or state decode only.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_and16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_and16
//  Description : Scoreboard bench for serial_and16. The driver pushes the
//                expected result on every operand acceptance; an independent
//                monitor pops and compares on every result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_and16;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   acc_cyc;
    bit   have_acc;
    bit   rand_phase;
    logic [WIDTH-1:0] exp_q[$];

    serial_and16_if #(.WIDTH(WIDTH)) bus ();

    serial_and16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Present operands and wait for acceptance; returns 1ns after accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit keep);
        int k = 0;
        @(negedge clk);
        bus.in0      = a;
        bus.in1      = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!bus.in_ready) begin
            timeout_fail("accept");
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(a & b);
        if (have_acc) chk("accept_spacing_ok", 32'((cyc + 1 - acc_cyc) >= WIDTH + 2), 32'd1);
        acc_cyc  = cyc + 1;
        have_acc = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0 || !bus.in_ready) timeout_fail("wait_idle");
    endtask

    // Monitor: checks every result handshake against the scoreboard plus
    // latency and hold-stability of the output.
    initial begin
        logic             pv;
        logic             ph;
        logic [WIDTH-1:0] po;
        pv = 1'b0;
        ph = 1'b0;
        po = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pv = 1'b0;
                ph = 1'b0;
            end else begin
                if (bus.out_valid && !pv)
                    chk("latency", 32'(cyc - acc_cyc), 32'(WIDTH));
                if (pv && !ph)
                    chk("valid_hold", 32'(bus.out_valid), 32'd1);
                if (bus.out_valid && pv && !ph)
                    chk("out_stable", 32'(bus.out), 32'(po));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %0h expected none", bus.out);
                    end else begin
                        chk("result", 32'(bus.out), 32'(exp_q.pop_front()));
                    end
                end
                pv = bus.out_valid;
                ph = bus.out_valid && bus.out_ready;
                po = bus.out;
            end
        end
    end

    // Random consumer backpressure during the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_phase) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        acc_cyc      = 0;
        have_acc     = 1'b0;
        rand_phase   = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in0      = '0;
        bus.in1      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Single operation with exact edge timing.
        bus.out_ready = 1'b1;
        send(16'hF0F0, 16'hFF00, 1'b0);
        chk("shift_busy", 32'(bus.busy), 32'd1);
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("done_valid", 32'(bus.out_valid), 32'd1);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        chk("done_out", 32'(bus.out), 32'hF000);
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
        wait_idle(50);

        // Boundary operands.
        send(16'hFFFF, 16'hFFFF, 1'b0); wait_idle(50);
        send(16'h0001, 16'h0001, 1'b0); wait_idle(50);
        send(16'h8000, 16'h7FFF, 1'b0); wait_idle(50);

        // Backpressure.
        send(16'hAAAA, 16'h5555, 1'b0); wait_idle(50);
        bus.out_ready = 1'b0;
        send(16'h1234, 16'hFFFF, 1'b1);
        begin
            int k = 0;
            while (!bus.out_valid && k < 40) begin
                @(negedge clk);
                #1;
                k++;
            end
            if (!bus.out_valid) timeout_fail("bp_wait_valid");
        end
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out", 32'(bus.out), 32'h1234);
            chk("bp_no_accept", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", 32'(bus.in_ready), 32'd1);
        chk("bp_busy", 32'(bus.busy), 32'd0);
        chk("bp_out_kept", 32'(bus.out), 32'h1234);
        wait_idle(50);

        // Operand changes during SHIFT must not affect the result.
        send(16'h3C5A, 16'h0FF0, 1'b0);
        repeat (WIDTH) begin
            @(negedge clk);
            bus.in0 = 16'($urandom);
            bus.in1 = 16'($urandom);
        end
        wait_idle(50);
        chk("stab_out_kept", 32'(bus.out), 32'h0C50);

        // Reset 5 edges into SHIFT, between edges.
        send(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        void'(exp_q.pop_back());
        have_acc = 1'b0;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_out", 32'(bus.out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) saw = 1'b1;
        end
        chk("mrst_no_valid", 32'(saw), 32'd0);

        // Random back-to-back traffic.
        rand_phase = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(a, b, 1'b0);
        end
        rand_phase = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_idle(100);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
